// File: rtl/score_pkg.sv
// Shared types, limits and small helpers for the score display path.
package score_pkg;
  localparam int NUM_DIGITS_MAX = 8;
  localparam int SCORE_W = 14;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 14'd9999;

  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
    return (s > SCORE_MAX) ? SCORE_MAX : s;
  endfunction

  function automatic bcd_t add3(input bcd_t d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction
endpackage

// File: rtl/score_bin2bcd.sv
// Multi-cycle shift-add-3 binary to BCD engine; one input bit per CONV cycle.
// start is honoured in IDLE and DONE, so back-to-back conversions need no idle gap.
module score_bin2bcd
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [SCORE_W-1:0]     bin,
  output logic                   busy,
  output logic                   done,
  output bcd_t [NUM_DIGITS-1:0]  bcd
);
  localparam int SH_W = NUM_DIGITS * 4 + SCORE_W;

  conv_state_e          state, state_nxt;
  logic [3:0]           cnt;
  logic [SH_W-1:0]      sh, sh_step;
  bcd_t [NUM_DIGITS-1:0] adj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (cnt == 4'(SCORE_W - 1)) state_nxt = DONE;
      DONE:    state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CONV) || (state == DONE);
    done = (state == DONE);
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adj
    assign adj[i] = add3(sh[SCORE_W + 4*i +: 4]);
  end

  // Correct every BCD column first, then shift the next binary bit in.
  assign sh_step = {adj, sh[SCORE_W-1:0]} << 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      cnt <= '0;
    end else if (start && state != CONV) begin
      sh  <= SH_W'(bin);
      cnt <= '0;
    end else if (state == CONV) begin
      sh  <= sh_step;
      cnt <= cnt + 4'd1;
    end
  end

  assign bcd = sh[SH_W-1 -: NUM_DIGITS*4];
endmodule

// File: rtl/score_display_ctrl.sv
// Score display sequencer: BCD conversion, frame-boundary commit and per-pixel sprite addressing.
// Build option: define SCORE_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module score_display_ctrl
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int X0         = 16,
  parameter int Y0         = 16,
  parameter int SCALE_LOG2 = 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [SCORE_W-1:0] score,
  input  logic               score_valid,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  output logic               busy,
  output logic [3:0]         rom_digit,
  output logic [7:0]         rom_address,
  output logic               draw_en
);
  localparam int CELL_W = 16 << SCALE_LOG2;
  localparam int BOX_W  = NUM_DIGITS * CELL_W;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  conv_busy, conv_done, conv_start;
  logic [SCORE_W-1:0]    score_sat, conv_bin, retry_val;
  logic                  retry_full;
  bcd_t [NUM_DIGITS-1:0] conv_bcd, pending_bcd, shown_bcd, disp_lr;
  logic [NUM_DIGITS-1:0] lz;
  logic [10:0]           rx, ry;
  logic [IDX_W-1:0]      digit_idx;
  logic [3:0]            col, row;
  logic                  hit;

  assign score_sat = sat_score(score);

  // A strobe landing in DONE wins over the retry slot and chains straight into CONV.
  assign conv_start = (!conv_busy && score_valid) || (conv_done && (score_valid || retry_full));
  assign conv_bin   = score_valid ? score_sat : retry_val;

  score_bin2bcd #(.NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign busy = conv_busy;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      retry_full <= 1'b0;
      retry_val  <= '0;
    end else if (conv_done) begin
      retry_full <= 1'b0;
    end else if (score_valid && conv_busy) begin
      retry_full <= 1'b1;
      retry_val  <= score_sat;
    end
  end

  // Shown digits only change on the last pixel of a frame.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_bcd <= '0;
      shown_bcd   <= '0;
    end else begin
      if (conv_done) pending_bcd <= conv_bcd;
      if (DrawX == 10'd639 && DrawY == 10'd479) shown_bcd <= pending_bcd;
    end
  end

  // disp_lr[0] is the leftmost (most significant) digit.
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_lr
    assign disp_lr[i] = shown_bcd[NUM_DIGITS-1-i];
  end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  always_comb begin : p_lz
    logic nz;
    nz = 1'b0;
    lz = '0;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      nz    = nz | (disp_lr[i] != 4'd0);
      lz[i] = !nz;
    end
  end
`else
  assign lz = '0;
`endif

  // Negative offsets wrap to bit 10 set, so they fail the inside test.
  assign rx        = {1'b0, DrawX} - 11'(X0);
  assign ry        = {1'b0, DrawY} - 11'(Y0);
  assign digit_idx = IDX_W'(rx >> (4 + SCALE_LOG2));
  assign col       = 4'(rx >> SCALE_LOG2);
  assign row       = 4'(ry >> SCALE_LOG2);
  assign hit       = blank && !rx[10] && !ry[10] &&
                     (rx < 11'(BOX_W)) && (ry < 11'(CELL_W)) && !lz[digit_idx];

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_digit   <= DIGIT_BLANK;
      rom_address <= '0;
      draw_en     <= 1'b0;
    end else if (hit) begin
      rom_digit   <= disp_lr[digit_idx];
      rom_address <= {row, col};
      draw_en     <= 1'b1;
    end else begin
      rom_digit   <= DIGIT_BLANK;
      rom_address <= '0;
      draw_en     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed bench for score_display_ctrl (NUM_DIGITS=4, X0=Y0=16, SCALE_LOG2=1).
// Expectations follow SCORE_LEADING_ZERO_BLANK_EN when the bench is built with it.
module tb_score_display_ctrl;
  localparam int X0 = 16;
  localparam int Y0 = 16;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        vga_clk = 1'b0;
  logic        reset_n, score_valid, blank;
  logic [13:0] score;
  logic [9:0]  DrawX, DrawY;
  logic        busy, draw_en;
  logic [3:0]  rom_digit;
  logic [7:0]  rom_address;

  int checks = 0;
  int failures = 0;

  score_display_ctrl #(.NUM_DIGITS(4), .X0(X0), .Y0(Y0), .SCALE_LOG2(1)) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .score       (score),
    .score_valid (score_valid),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .busy        (busy),
    .rom_digit   (rom_digit),
    .rom_address (rom_address),
    .draw_en     (draw_en)
  );

  initial forever #5 vga_clk = ~vga_clk;

  // Expected-value model: leading-zero suppression of a 4-digit BCD word.
  function automatic bit lead_blank(input logic [15:0] bcd, input int i);
    bit all_zero = 1'b1;
    if (!LZB || i >= 3) return 1'b0;
    for (int j = 0; j <= i; j++)
      if (bcd[(3-j)*4 +: 4] != 4'd0) all_zero = 1'b0;
    return all_zero;
  endfunction

  function automatic logic [3:0] exp_cell(input logic [15:0] bcd, input int i);
    return lead_blank(bcd, i) ? 4'hF : bcd[(3-i)*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic set_pixel(input int x, input int y);
    DrawX = 10'(x);
    DrawY = 10'(y);
  endtask

  task automatic read_cell(input int i, output logic [3:0] d, output logic en);
    set_pixel(X0 + i*32 + 5, Y0 + 3);
    tick();
    d  = rom_digit;
    en = draw_en;
    set_pixel(0, 0);
  endtask

  task automatic commit_frame();
    set_pixel(639, 479);
    tick();
    set_pixel(0, 0);
  endtask

  task automatic strobe(input int v);
    score       = 14'(v);
    score_valid = 1'b1;
    tick();
    score_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_pixel(X0, Y0);
    repeat (3) tick();
    checks += 4;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (rom_digit !== 4'hF) begin failures++; $display("FAIL reset_digit: got %h expected f", rom_digit); end
    if (rom_address !== 8'h00) begin failures++; $display("FAIL reset_addr: got %h expected 00", rom_address); end
    if (draw_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", draw_en); end
    #3 reset_n = 1'b1;
    set_pixel(0, 0);
    tick();
  endtask

  task automatic test_conv_42();
    int n;
    logic [3:0] d;
    logic en;
    strobe(42);
    n = 0;
    while (busy && n < 100) begin n++; tick(); end
    checks++;
    if (n !== 15) begin failures++; $display("FAIL busy_len_42: got %0d expected 15", n); end
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks += 2;
      if (d !== exp_cell(16'h0000, i)) begin failures++; $display("FAIL precommit_digit%0d: got %h expected %h", i, d, exp_cell(16'h0000, i)); end
      if (en !== !lead_blank(16'h0000, i)) begin failures++; $display("FAIL precommit_en%0d: got %b expected %b", i, en, !lead_blank(16'h0000, i)); end
    end
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks += 2;
      if (d !== exp_cell(16'h0042, i)) begin failures++; $display("FAIL show42_digit%0d: got %h expected %h", i, d, exp_cell(16'h0042, i)); end
      if (en !== !lead_blank(16'h0042, i)) begin failures++; $display("FAIL show42_en%0d: got %b expected %b", i, en, !lead_blank(16'h0042, i)); end
    end
  endtask

  // Shown value is 0042 here; cell -1 means outside the box.
  task automatic test_addr();
    int vx[10], vy[10], vcell[10];
    logic vbl[10];
    logic [7:0] vaddr[10];
    logic [3:0] ed;
    logic ee;
    logic [7:0] ea;
    vx    = '{16,   49,    143,   15,  144, 16,  16,  0,   80,  80};
    vy    = '{16,   47,    47,    16,  16,  48,  15,  0,   30,  30};
    vbl   = '{1,    1,     1,     1,   1,   1,   1,   1,   0,   1};
    vcell = '{0,    1,     3,     -1,  -1,  -1,  -1,  -1,  -1,  2};
    vaddr = '{8'h00,8'hF0, 8'hFF, 0,   0,   0,   0,   0,   0,   8'h70};
    for (int k = 0; k < 10; k++) begin
      set_pixel(vx[k], vy[k]);
      blank = vbl[k];
      tick();
      ee = (vcell[k] >= 0) && !lead_blank(16'h0042, vcell[k]);
      ed = (vcell[k] >= 0) ? exp_cell(16'h0042, vcell[k]) : 4'hF;
      ea = ee ? vaddr[k] : 8'h00;
      checks += 3;
      if (rom_digit !== ed) begin failures++; $display("FAIL addr_digit v%0d: got %h expected %h", k, rom_digit, ed); end
      if (rom_address !== ea) begin failures++; $display("FAIL addr_addr v%0d: got %h expected %h", k, rom_address, ea); end
      if (draw_en !== ee) begin failures++; $display("FAIL addr_en v%0d: got %b expected %b", k, draw_en, ee); end
    end
    blank = 1'b1;
    set_pixel(0, 0);
  endtask

  task automatic test_saturate();
    int n;
    logic [3:0] d;
    logic en;
    strobe(12000);
    wait_idle(n);
    checks++;
    if (n >= 100) begin failures++; $display("FAIL sat_timeout: busy still %b after %0d cycles", busy, n); end
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks += 2;
      if (d !== 4'd9) begin failures++; $display("FAIL sat_digit%0d: got %h expected 9", i, d); end
      if (en !== 1'b1) begin failures++; $display("FAIL sat_en%0d: got %b expected 1", i, en); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [3:0] d;
    logic en;
    // 5 converts, 7 is overwritten by 9 in the retry slot, 9 converts next.
    strobe(5);
    n = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      score_valid = 1'b0;
      if (k == 3) begin score = 14'd7; score_valid = 1'b1; end
      if (k == 6) begin score = 14'd9; score_valid = 1'b1; end
      if (k == 20) set_pixel(639, 479); else set_pixel(0, 0);
      tick();
      if (busy) n++;
    end
    score_valid = 1'b0;
    set_pixel(0, 0);
    checks++;
    if (n !== 30) begin failures++; $display("FAIL retry_busy_len: got %0d expected 30", n); end
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks++;
      if (d !== exp_cell(16'h0005, i)) begin failures++; $display("FAIL retry_first_digit%0d: got %h expected %h", i, d, exp_cell(16'h0005, i)); end
    end
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks++;
      if (d !== exp_cell(16'h0009, i)) begin failures++; $display("FAIL retry_last_digit%0d: got %h expected %h", i, d, exp_cell(16'h0009, i)); end
    end
    // Strobe landing exactly in the DONE cycle of a conversion of 3.
    strobe(3);
    n = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      score_valid = 1'b0;
      if (k == 15) begin score = 14'd8; score_valid = 1'b1; end
      tick();
      if (busy) n++;
    end
    score_valid = 1'b0;
    checks++;
    if (n !== 30) begin failures++; $display("FAIL done_strobe_busy_len: got %0d expected 30", n); end
    commit_frame();
    read_cell(3, d, en);
    checks++;
    if (d !== 4'd8) begin failures++; $display("FAIL done_strobe_digit: got %h expected 8", d); end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [3:0] d;
    logic en;
    set_pixel(X0 + 96 + 1, Y0);
    strobe(1234);
    repeat (4) tick();
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL midreset_pre_busy: got %b expected 1", busy); end
    if (draw_en !== 1'b1) begin failures++; $display("FAIL midreset_pre_en: got %b expected 1", draw_en); end
    #2 reset_n = 1'b0;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    if (draw_en !== 1'b0) begin failures++; $display("FAIL midreset_en: got %b expected 0", draw_en); end
    if (rom_digit !== 4'hF) begin failures++; $display("FAIL midreset_digit: got %h expected f", rom_digit); end
    #3 reset_n = 1'b1;
    set_pixel(0, 0);
    repeat (20) tick();
    n = busy ? 1 : 0;
    checks++;
    if (n !== 0) begin failures++; $display("FAIL midreset_idle: busy got %b expected 0", busy); end
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks++;
      if (d !== exp_cell(16'h0000, i)) begin failures++; $display("FAIL midreset_digit%0d: got %h expected %h", i, d, exp_cell(16'h0000, i)); end
    end
  endtask

  task automatic test_leading_zero();
    int n;
    logic [3:0] d;
    logic en;
    strobe(7);
    wait_idle(n);
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks += 2;
      if (d !== exp_cell(16'h0007, i)) begin failures++; $display("FAIL lz7_digit%0d: got %h expected %h", i, d, exp_cell(16'h0007, i)); end
      if (en !== !lead_blank(16'h0007, i)) begin failures++; $display("FAIL lz7_en%0d: got %b expected %b", i, en, !lead_blank(16'h0007, i)); end
    end
    strobe(0);
    wait_idle(n);
    commit_frame();
    for (int i = 0; i < 4; i++) begin
      read_cell(i, d, en);
      checks += 2;
      if (d !== exp_cell(16'h0000, i)) begin failures++; $display("FAIL lz0_digit%0d: got %h expected %h", i, d, exp_cell(16'h0000, i)); end
      if (en !== !lead_blank(16'h0000, i)) begin failures++; $display("FAIL lz0_en%0d: got %b expected %b", i, en, !lead_blank(16'h0000, i)); end
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    score       = '0;
    score_valid = 1'b0;
    blank       = 1'b1;
    set_pixel(X0, Y0);
    test_reset();
    test_conv_42();
    test_addr();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    test_leading_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
